// File: rtl/imm_gen_pkg.sv
// Shared types and opcode constants for the pipelined immediate generator.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_S    = 3'd0,
    FMT_I    = 3'd1,
    FMT_J    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_Z    = 3'd5,
    FMT_SH   = 3'd6,
    FMT_NONE = 3'd7
  } imm_fmt_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: gathers the instruction bits for a format and extends to XLEN.
module imm_extract
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  // Signed 32-bit immediates widen to XLEN by replicating bit 31.
  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_S:  imm = sext({{20{instr[31]}}, instr[31:25], instr[11:7]});
      FMT_I:  imm = sext({{20{instr[31]}}, instr[31:20]});
      FMT_J:  imm = sext({{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0});
      FMT_B:  imm = sext({{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0});
      FMT_U:  imm = sext({instr[31:12], 12'b0});
      FMT_Z:  imm = XLEN'(instr[19:15]);
      FMT_SH: imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage valid/ready immediate generator: stage 1 resolves the format, stage 2 holds the extended result.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit AUTO_SEL = 1'b1,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  imm_fmt_e         auto_fmt, fmt_in;
  logic             auto_ill, ill_in;
  logic             adv_p1, adv_p2, load_p1, acc;
  logic             vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic [31:7]      instr_p1_q, instr_p1_d;
  imm_fmt_e         fmt_p1_q, fmt_p1_d, fmt_p2_q, fmt_p2_d;
  logic             ill_p1_q, ill_p1_d, ill_p2_q, ill_p2_d;
  logic [TAG_W-1:0] tag_p1_q, tag_p1_d, tag_p2_q, tag_p2_d;
  logic [XLEN-1:0]  imm_x, imm_p2_q, imm_p2_d;

  always_comb begin
    auto_fmt = FMT_NONE;
    auto_ill = 1'b0;
    case (in_instr[6:0])
      OP_IMM:    auto_fmt = (in_instr[13:12] == 2'b01) ? FMT_SH : FMT_I;
      OP_LOAD, OP_JALR, OP_FENCE: auto_fmt = FMT_I;
      OP_SYSTEM: auto_fmt = in_instr[14] ? FMT_Z : FMT_I;
      OP_STORE:  auto_fmt = FMT_S;
      OP_BRANCH: auto_fmt = FMT_B;
      OP_JAL:    auto_fmt = FMT_J;
      OP_LUI, OP_AUIPC: auto_fmt = FMT_U;
      OP_REG, OP_REG32: auto_fmt = FMT_NONE;
      default:   auto_ill = 1'b1;
    endcase
    fmt_in = AUTO_SEL ? auto_fmt : imm_fmt_e'(in_sel);
    ill_in = AUTO_SEL ? auto_ill : (in_sel == 3'b111);
  end

  always_comb begin
    adv_p2   = !vld_p2_q || out_ready;
    adv_p1   = vld_p1_q && adv_p2;
    load_p1  = !vld_p1_q || adv_p1;
    in_ready = load_p1 && !flush;
    acc      = in_valid && in_ready;

    vld_p1_d = flush ? 1'b0 : (load_p1 ? acc : vld_p1_q);
    vld_p2_d = flush ? 1'b0 : (adv_p2 ? vld_p1_q : vld_p2_q);

    instr_p1_d = acc ? in_instr[31:7] : instr_p1_q;
    fmt_p1_d   = acc ? fmt_in : fmt_p1_q;
    ill_p1_d   = acc ? ill_in : ill_p1_q;
    tag_p1_d   = acc ? in_tag : tag_p1_q;

    imm_p2_d = adv_p1 ? imm_x : imm_p2_q;
    fmt_p2_d = adv_p1 ? fmt_p1_q : fmt_p2_q;
    ill_p2_d = adv_p1 ? ill_p1_q : ill_p2_q;
    tag_p2_d = adv_p1 ? tag_p1_q : tag_p2_q;
  end

  // Stage 1 -> stage 2: extraction sits between the two register banks.
  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr (instr_p1_q),
    .fmt   (fmt_p1_q),
    .imm   (imm_x)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      imm_p2_q <= '0;
      fmt_p2_q <= FMT_NONE;
      ill_p2_q <= 1'b0;
      tag_p2_q <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      imm_p2_q <= imm_p2_d;
      fmt_p2_q <= fmt_p2_d;
      ill_p2_q <= ill_p2_d;
      tag_p2_q <= tag_p2_d;
    end
  end

  // Stage 1 data is qualified by vld_p1_q, so it needs no reset.
  always_ff @(posedge clk) begin
    instr_p1_q <= instr_p1_d;
    fmt_p1_q   <= fmt_p1_d;
    ill_p1_q   <= ill_p1_d;
    tag_p1_q   <= tag_p1_d;
  end

  assign out_valid   = vld_p2_q;
  assign out_imm     = imm_p2_q;
  assign out_fmt     = fmt_p2_q;
  assign out_illegal = ill_p2_q;
  assign out_tag     = tag_p2_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32/auto, XLEN=64/auto and XLEN=32/sel instances driven in lockstep.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [2:0]  in_sel;
  logic [3:0]  in_tag;

  logic        r32, r64, rm, ov32, ov64, ovm, il32, il64, ilm;
  logic [31:0] o32_imm, om_imm;
  logic [63:0] o64_imm;
  logic [2:0]  f32, f64, fm;
  logic [3:0]  t32, t64, tm;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .AUTO_SEL(1'b1), .TAG_W(4)) u32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r32),
    .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag), .out_valid(ov32),
    .out_ready(out_ready), .out_imm(o32_imm), .out_fmt(f32), .out_illegal(il32), .out_tag(t32));

  imm_gen_pipe #(.XLEN(64), .AUTO_SEL(1'b1), .TAG_W(4)) u64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r64),
    .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag), .out_valid(ov64),
    .out_ready(out_ready), .out_imm(o64_imm), .out_fmt(f64), .out_illegal(il64), .out_tag(t64));

  imm_gen_pipe #(.XLEN(32), .AUTO_SEL(1'b0), .TAG_W(4)) um (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rm),
    .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag), .out_valid(ovm),
    .out_ready(out_ready), .out_imm(om_imm), .out_fmt(fm), .out_illegal(ilm), .out_tag(tm));

  typedef struct {
    logic [63:0] i32, i64, im;
    logic [2:0]  fa, fs;
    logic        la, ls;
    logic [3:0]  tag;
  } exp_t;

  exp_t       q[$];
  logic [3:0] got_tags[$];
  int         checks = 0;
  int         errors = 0;
  bit         last_acc, saw_stall;
  logic [6:0] ops[14] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011,
                          7'b0100011, 7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111,
                          7'b0110011, 7'b0111011, 7'b1111111, 7'b0000000};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Format decode from the opcode table; returns {illegal, fmt}.
  function automatic logic [3:0] mdec(input logic [31:0] x);
    logic [2:0] f3;
    f3 = x[14:12];
    case (x[6:0])
      7'b0010011: return (f3 == 3'd1 || f3 == 3'd5) ? 4'd6 : 4'd1;
      7'b0000011, 7'b1100111, 7'b0001111: return 4'd1;
      7'b1110011: return f3[2] ? 4'd5 : 4'd1;
      7'b0100011: return 4'd0;
      7'b1100011: return 4'd3;
      7'b1101111: return 4'd2;
      7'b0110111, 7'b0010111: return 4'd4;
      7'b0110011, 7'b0111011: return 4'd7;
      default: return 4'b1111;
    endcase
  endfunction

  // Immediate value as a plain integer built from weighted instruction fields.
  function automatic longint mimm(input logic [31:0] x, input logic [2:0] f, input int xlen);
    longint v;
    case (f)
      3'd0: v = longint'($signed(x[31:25])) * 32 + longint'(x[11:7]);
      3'd1: v = longint'($signed(x[31:20]));
      3'd2: v = longint'(x[19:12]) * 4096 + longint'(x[20]) * 2048 + longint'(x[30:21]) * 2
                - (x[31] ? 64'sd1048576 : 64'sd0);
      3'd3: v = longint'(x[7]) * 2048 + longint'(x[30:25]) * 32 + longint'(x[11:8]) * 2
                - (x[31] ? 64'sd4096 : 64'sd0);
      3'd4: v = longint'($signed(x[31:12])) * 4096;
      3'd5: v = longint'(x[19:15]);
      3'd6: v = (xlen == 64) ? longint'(x[25:20]) : longint'(x[24:20]);
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic logic [63:0] lo32(input longint v);
    logic [63:0] t;
    t = v;
    return {32'b0, t[31:0]};
  endfunction

  task automatic step(input bit v, input logic [31:0] ins, input logic [2:0] sel,
                      input logic [3:0] tag, input bit ordy, input bit fl, input bit r);
    exp_t e;
    bit erdy;
    logic [3:0] d;
    rst = r; flush = fl; in_valid = v; in_instr = ins; in_sel = sel; in_tag = tag;
    out_ready = ordy;
    #1;
    last_acc = 1'b0;
    if (!r) begin
      erdy = !fl && (q.size() < 2 || ordy);
      if (!erdy) saw_stall = 1'b1;
      chk("in_ready32", r32, erdy);
      chk("in_ready64", r64, erdy);
      chk("in_ready_sel", rm, erdy);
      if (q.size() == 0) begin
        chk("idle_valid32", ov32, 0);
        chk("idle_valid64", ov64, 0);
        chk("idle_valid_sel", ovm, 0);
      end else begin
        e = q[0];
        if (ov32) begin
          chk("imm32", o32_imm, e.i32); chk("fmt32", f32, e.fa);
          chk("ill32", il32, e.la);     chk("tag32", t32, e.tag);
        end
        if (ov64) begin
          chk("imm64", o64_imm, e.i64); chk("fmt64", f64, e.fa);
          chk("ill64", il64, e.la);     chk("tag64", t64, e.tag);
        end
        if (ovm) begin
          chk("imm_sel", om_imm, e.im); chk("fmt_sel", fm, e.fs);
          chk("ill_sel", ilm, e.ls);    chk("tag_sel", tm, e.tag);
        end
        if (ov32 && ordy && !fl) begin
          got_tags.push_back(e.tag);
          void'(q.pop_front());
        end
      end
      last_acc = v && erdy;
      if (last_acc) begin
        d     = mdec(ins);
        e.fa  = d[2:0];
        e.la  = d[3];
        e.fs  = sel;
        e.ls  = (sel == 3'b111);
        e.i32 = lo32(mimm(ins, d[2:0], 32));
        e.i64 = mimm(ins, d[2:0], 64);
        e.im  = lo32(mimm(ins, sel, 32));
        e.tag = tag;
        q.push_back(e);
      end
    end
    @(posedge clk); #1;
    if (r || fl) q.delete();
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 20) begin
      step(1'b0, 32'h0, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      n++;
    end
    chk("drain_budget", q.size(), 0);
  endtask

  // Offer one instruction on an empty pipe; leaves it presented on the outputs.
  task automatic probe(input logic [31:0] ins, input logic [2:0] sel, input logic [3:0] tag);
    step(1'b1, ins, sel, tag, 1'b1, 1'b0, 1'b0);
    chk("latency_c1", ov32, 0);
    step(1'b0, 32'h0, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    chk("latency_c2", ov32, 1);
  endtask

  task automatic chk_reset();
    chk("rst_valid32", ov32, 0); chk("rst_imm32", o32_imm, 0);
    chk("rst_fmt32", f32, 3'd7); chk("rst_ill32", il32, 0); chk("rst_tag32", t32, 0);
    chk("rst_valid64", ov64, 0); chk("rst_imm64", o64_imm, 0); chk("rst_fmt64", f64, 3'd7);
    chk("rst_valid_sel", ovm, 0); chk("rst_tag_sel", tm, 0);
  endtask

  initial begin
    logic [31:0] rnd;
    int sent, c;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_sel = '0; in_tag = '0;
    @(posedge clk); #1;
    step(1'b0, 32'h0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 3'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    chk_reset();

    probe(32'hFFF00093, 3'd1, 4'd1);
    chk("addi_imm", o32_imm, 32'hFFFFFFFF); chk("addi_fmt", f32, 3'd1);
    probe(32'hFE000EE3, 3'd1, 4'd2);
    chk("beq_imm", o32_imm, 32'hFFFFFFFC); chk("beq_fmt", f32, 3'd3);
    chk("sel_i_imm", om_imm, 32'hFFFFFFE0); chk("sel_i_ill", ilm, 0);
    probe(32'h300FD073, 3'd5, 4'd3);
    chk("csr_imm", o32_imm, 32'h1F); chk("csr_fmt", f32, 3'd5);
    probe(32'h800000B7, 3'd4, 4'd4);
    chk("lui64_imm", o64_imm, 64'hFFFFFFFF80000000); chk("lui32_imm", o32_imm, 32'h80000000);
    probe(32'h03F0D093, 3'd6, 4'd5);
    chk("srli64_imm", o64_imm, 64'h3F); chk("srli64_fmt", f64, 3'd6);
    probe(32'h0000007F, 3'b111, 4'd6);
    chk("bad_fmt", f32, 3'd7); chk("bad_ill", il32, 1); chk("bad_imm", o32_imm, 0);
    chk("sel7_ill", ilm, 1);
    drain();

    sent = 0; c = 0; saw_stall = 1'b0; got_tags.delete();
    while ((sent < 6 || q.size() > 0) && c < 40) begin
      rnd = $urandom();
      step(sent < 6, {rnd[31:7], ops[c % 12]}, rnd[2:0], sent[3:0], !(c >= 3 && c <= 5),
           1'b0, 1'b0);
      if (last_acc) sent++;
      c++;
    end
    chk("stream_budget", c < 40, 1);
    chk("stream_stall_seen", saw_stall, 1);
    chk("stream_count", got_tags.size(), 6);
    for (int i = 0; i < 6 && i < got_tags.size(); i++) chk("stream_order", got_tags[i], i);

    step(1'b1, 32'h00100093, 3'd1, 4'd7, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00200093, 3'd1, 4'd8, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h00300093, 3'd1, 4'd9, 1'b0, 1'b1, 1'b0);
    chk("flush_valid32", ov32, 0); chk("flush_valid64", ov64, 0); chk("flush_valid_sel", ovm, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      chk("flush_nothing_left", ov32, 0);
    end
    step(1'b1, 32'hFFF00093, 3'd1, 4'd10, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hFE000EE3, 3'd3, 4'd11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h800000B7, 3'd4, 4'd12, 1'b0, 1'b0, 1'b1);
    chk_reset();

    for (int i = 0; i < 400; i++) begin
      rnd = $urandom();
      step($urandom_range(0, 3) != 0, {rnd[31:7], ops[$urandom_range(0, 13)]},
           3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 29) == 0, 1'b0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
